// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS execute-stage encodings and mul/div FSM states
package mips_pkg;

  localparam logic [4:0] ALU_DIVU  = 5'b00010;
  localparam logic [4:0] ALU_MULTU = 5'b01000;
  localparam logic [4:0] ALU_MULT  = 5'b11010;
  localparam logic [4:0] ALU_DIV   = 5'b11011;
  localparam logic [4:0] ALU_MTHI  = 5'b10000;
  localparam logic [4:0] ALU_MTLO  = 5'b10010;
  localparam logic [4:0] ALU_MFHI  = 5'b10001;
  localparam logic [4:0] ALU_MFLO  = 5'b10011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_seq_if.sv
// rtl/mips_muldiv_seq_if.sv - op handshake and HI/LO read bus of the mul/div sequencer
interface mips_muldiv_seq_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [4:0]       op_code;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             op_ready;
  logic             rd_req;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             stall;
  logic             busy;
  logic             done;
  logic             flush;

  modport master (
    output op_valid, op_code, src_a, src_b, rd_req, rd_sel, flush,
    input  op_ready, rd_data, stall, busy, done
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, rd_req, rd_sel, flush,
    output op_ready, rd_data, stall, busy, done
  );
endinterface

// File: rtl/mips_div_step.sv
// rtl/mips_div_step.sv - one combinational restoring-divide iteration
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quot_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign shifted = {rem_i, quot_i[WIDTH-1]};
  assign diff    = shifted - {2'b00, divisor_i};
  // Borrow means the trial subtract went negative: keep the shifted value.
  assign borrow  = diff[WIDTH+1];
  assign rem_o   = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
  assign quot_o  = {quot_i[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - multi-cycle shift-add multiply / restoring divide owning HI/LO
module mips_muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mips_muldiv_seq_if.slave         bus
);
  muldiv_state_t      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_res_q, neg_rem_q, dz_q, is_div_q, done_q;

  logic               op_ready, accept, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d, prod_fix;
  logic [WIDTH:0]     div_rem_d;
  logic [WIDTH-1:0]   div_quot_d, quot_fix, rem_fix;

  assign op_ready  = (state_q == IDLE);
  assign accept    = bus.op_valid & op_ready & ~bus.flush;
  assign is_signed = (bus.op_code == ALU_MULT) || (bus.op_code == ALU_DIV);
  assign a_neg     = is_signed & bus.src_a[WIDTH-1];
  assign b_neg     = is_signed & bus.src_b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag     = b_neg ? -bus.src_b : bus.src_b;

  // Upper half accumulates the multiplicand; the multiplier drains out of the lower half.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quot_i    (acc_q[WIDTH-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem_d),
    .quot_o    (div_quot_d)
  );

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (bus.op_code)
              ALU_MULT, ALU_MULTU: begin
                state_q   <= MUL;
                cnt_q     <= '0;
                acc_q     <= {{WIDTH{1'b0}}, b_mag};
                opnd_q    <= a_mag;
                neg_res_q <= a_neg ^ b_neg;
                is_div_q  <= 1'b0;
              end
              ALU_DIV, ALU_DIVU: begin
                state_q   <= DIV;
                cnt_q     <= '0;
                acc_q     <= {{WIDTH{1'b0}}, a_mag};
                rem_q     <= '0;
                opnd_q    <= b_mag;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                dz_q      <= (bus.src_b == '0);
                is_div_q  <= 1'b1;
              end
              ALU_MTHI: hi_q <= bus.src_a;
              ALU_MTLO: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            if (state_q == MUL) begin
              acc_q <= mul_acc_d;
            end else begin
              acc_q[WIDTH-1:0] <= div_quot_d;
              rem_q            <= div_rem_d;
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              // Divide-by-zero: the magnitude path already leaves |src_a| as remainder,
              // and the dividend-sign fixup restores the original src_a.
              lo_q <= dz_q ? '1 : quot_fix;
              hi_q <= rem_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.op_ready = op_ready;
  assign bus.busy     = ~op_ready;
  assign bus.done     = done_q;
  assign bus.stall    = (bus.rd_req & ~op_ready) | (bus.op_valid & ~op_ready);
  assign bus.rd_data  = bus.rd_sel ? lo_q : hi_q;
endmodule

// File: tb/tb_mips_muldiv_seq.sv
// tb/tb_mips_muldiv_seq.sv - scoreboard bench for the mul/div sequencer
module tb_mips_muldiv_seq;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_muldiv_seq_if #(.WIDTH(32)) bus ();

  mips_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic stim_sel, mon_sel, mon_active;
  assign bus.rd_sel = mon_active ? mon_sel : stim_sel;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.src_a    = a;
    bus.src_b    = b;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
  endtask

  // Monitor: every done pulse pops one expected HI/LO pair and reads both through rd_data.
  initial begin
    exp_t e;
    mon_active = 1'b0;
    mon_sel    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          mon_active = 1'b1;
          mon_sel    = 1'b0;
          #1 check({e.name, "_hi"}, bus.rd_data, e.hi);
          mon_sel    = 1'b1;
          #1 check({e.name, "_lo"}, bus.rd_data, e.lo);
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int lat, bad, seen;
    bus.op_valid = 1'b0;
    bus.op_code  = '0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.rd_req   = 1'b0;
    bus.flush    = 1'b0;
    stim_sel     = 1'b0;

    vecs[0] = '{"multu_max",  ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg",   ALU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"div_neg",    ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_zero",  ALU_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4] = '{"div_ovf",    ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{"div_zero_s", ALU_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
    vecs[6] = '{"mult_minsq", ALU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{"div_negb",   ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_op_ready", 32'(bus.op_ready), 32'd1);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_stall",    32'(bus.stall),    32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_hi",       bus.rd_data,       32'd0);
    stim_sel = 1'b1;
    #1 check("rst_lo", bus.rd_data, 32'd0);
    stim_sel = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      push_exp(vecs[i].name, vecs[i].hi, vecs[i].lo);
      issue(vecs[i].code, vecs[i].a, vecs[i].b);
      wait_done(lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd34);
    end

    // MFLO/MFHI while a DIVU is in flight.
    push_exp("divu_10_3", 32'd1, 32'd3);
    issue(ALU_DIVU, 32'd10, 32'd3);
    bus.rd_req = 1'b1;
    stim_sel   = 1'b1;
    bad = 0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.stall !== 1'b1) bad++;
    end
    check("rd_stall_latency", 32'(lat), 32'd34);
    check("rd_stall_gaps",    32'(bad), 32'd0);
    check("rd_stall_release", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("mflo_after_done", bus.rd_data, 32'd3);
    stim_sel = 1'b0;
    #1 check("mfhi_after_done", bus.rd_data, 32'd1);
    bus.rd_req = 1'b0;

    issue(ALU_MTHI, 32'h00001234, 32'd0);
    @(negedge clk);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    check("mthi_hi",   bus.rd_data,   32'h00001234);

    // MTLO held while a MULTU runs; accepted on the first idle edge.
    push_exp("multu_5_6", 32'd0, 32'd30);
    issue(ALU_MULTU, 32'd5, 32'd6);
    bus.op_valid = 1'b1;
    bus.op_code  = ALU_MTLO;
    bus.src_a    = 32'h0000ABCD;
    bad = 0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.op_ready !== 1'b0 || bus.stall !== 1'b1) bad++;
    end
    check("mtlo_wait_latency", 32'(lat), 32'd34);
    check("mtlo_wait_gaps",    32'(bad), 32'd0);
    check("mtlo_ready_at_done", 32'(bus.op_ready), 32'd1);
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    stim_sel = 1'b1;
    @(negedge clk);
    check("mtlo_lo", bus.rd_data, 32'h0000ABCD);
    stim_sel = 1'b0;

    // Flush mid-multiply.
    issue(ALU_MTLO, 32'd0, 32'd0);
    issue(ALU_MULTU, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush_busy",  32'(bus.busy),     32'd0);
    check("flush_ready", 32'(bus.op_ready), 32'd1);
    count_done(40, seen);
    check("flush_no_done", 32'(seen), 32'd0);
    stim_sel = 1'b0;
    #1 check("flush_hi", bus.rd_data, 32'd0);
    stim_sel = 1'b1;
    #1 check("flush_lo", bus.rd_data, 32'd0);
    stim_sel = 1'b0;

    // Flush in IDLE blocks an MTHI.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = ALU_MTHI;
    bus.src_a    = 32'h00000055;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_hi", bus.rd_data, 32'd0);

    // Flush coinciding with FIX.
    issue(ALU_MULTU, 32'd5, 32'd6);
    repeat (32) @(posedge clk);
    #1 check("fix_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("fix_flush_busy", 32'(bus.busy), 32'd0);
    count_done(5, seen);
    check("fix_flush_no_done", 32'(seen), 32'd0);
    stim_sel = 1'b1;
    #1 check("fix_flush_lo", bus.rd_data, 32'd0);
    stim_sel = 1'b0;

    // Asynchronous reset mid-multiply.
    issue(ALU_MTHI, 32'h00000077, 32'd0);
    issue(ALU_MULTU, 32'd5, 32'd6);
    repeat (20) @(posedge clk);
    #1 check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(bus.busy),     32'd0);
    check("arst_ready", 32'(bus.op_ready), 32'd1);
    check("arst_stall", 32'(bus.stall),    32'd0);
    check("arst_done",  32'(bus.done),     32'd0);
    check("arst_hi",    bus.rd_data,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push_exp("post_rst_multu", 32'd0, 32'd30);
    issue(ALU_MULTU, 32'd5, 32'd6);
    wait_done(lat);
    check("post_rst_latency", 32'(lat), 32'd34);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_seq.md
Name: mips_muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair.
- Replaces single-cycle `*` / `/` / `%` with one-bit-per-cycle shift-add multiply and restoring divide.
- Sits beside the ALU in the execute stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO through a valid/ready handshake.
- Serves MFHI/MFLO reads, and raises a stall while a result is pending.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation request
- op_code  in  5  ALUControl encoding: 00010 DIVU, 01000 MULTU, 11010 MULT, 11011 DIV, 10000 MTHI, 10010 MTLO; other codes ignored
- src_a  in  WIDTH  rs operand (dividend / multiplicand / MT data)
- src_b  in  WIDTH  rt operand (divisor / multiplier)
- op_ready  out  1  high when the unit can accept an op (state IDLE)
- rd_req  in  1  MFHI/MFLO read request
- rd_sel  in  1  0 = HI, 1 = LO
- rd_data  out  WIDTH  combinational HI or LO per rd_sel
- stall  out  1  rd_req & busy, or op_valid & ~op_ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when HI/LO are written by MUL/DIV
- flush  in  1  synchronous abort (exception / branch squash)

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, state=IDLE, counter=0, done=0.
  - Outputs after reset: op_ready=1, busy=0, stall=0.
- Accept rule: an op is accepted on the edge where op_valid & op_ready.
  - MTHI/MTLO write HI or LO at that edge; the unit stays in IDLE and done is not pulsed.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on an accepted MULT/MULTU; IDLE -> DIV on an accepted DIV/DIVU.
  - MUL/DIV -> FIX after WIDTH iterations.
  - FIX -> IDLE after one cycle; HI/LO are written and done=1 in that cycle's edge.
- Latency: accept at edge E0, iterations on E1..E32, HI/LO valid after E33.
  - done is high in the cycle following E33.
  - A back-to-back op may be accepted at the earliest at E34.
- Signed ops: operands are latched as magnitudes at accept, along with their sign bits.
  - FIX negates the product if the signs differ.
  - FIX negates the quotient if the signs differ; the remainder takes the dividend's sign.
- Multiply: 2*WIDTH-bit accumulator, shift-add on the LSB of the multiplier; the full 64-bit product goes to {HI,LO}.
- Divide: restoring; one quotient bit per cycle; the remainder register is WIDTH+1 bits to hold the subtract borrow.
- Divide by zero (src_b=0, signed or unsigned): LO=all ones, HI=src_a as originally supplied (no sign fixup).
  - Same latency as a normal divide.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Reads: rd_data is always the architectural HI/LO.
  - While busy, rd_req asserts stall and rd_data is not meaningful; the consumer holds the request.
- While busy, op_valid is not accepted; stall=1 until op_ready.
- flush: when busy, the unit returns to IDLE at the next edge, HI/LO keep their prior values, and done is not pulsed.
  - flush in IDLE blocks acceptance in that cycle.
- flush and FIX in the same cycle: the flush wins and HI/LO are not written.
- A reset asserted mid-operation aborts immediately to the reset values.

Decomposition:
- Shared package mips_pkg holds:
  - the ALUControl 5-bit localparams: ALU_DIVU, ALU_MULTU, ALU_MULT, ALU_DIV, ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO;
  - the typedef enum muldiv_state_t {IDLE, MUL, DIV, FIX}.
- One natural sub-module: mips_div_step, a combinational single restoring-divide iteration (remainder/quotient in, remainder/quotient out). It is reused by a future radix-4 variant.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 * 7 -> {HI,LO}=0xFFFFFFFF_FFFFFFEB. DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU 10/3 then MFLO rd_req at E1 -> stall=1 through E33; after done, rd_data=3. MFHI -> 1.
- MTHI 0x1234 accepted in IDLE -> HI=0x1234 next cycle, busy=0. MTLO while busy -> op_ready=0 and stall=1 until done, then accepted.
- Start MULTU 5*6, flush at E10 -> IDLE at E11, HI/LO unchanged (previous 0/0), no done pulse. Repeat with rst_n pulsed low at E20 -> all outputs return to reset values asynchronously.
